// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - Clause-22 MDIO master: MDC generation and single read/write frame serialiser
// One request at a time; read data and turnaround error are published on the DONE cycle.
module mdio_master #(
  parameter int CLK_DIV     = 10,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic        sig_CLK,
  input  logic        sig_RST,
  input  logic        sig_REQ,
  input  logic        sig_WRITE,
  input  logic [4:0]  sig_PHY_ADDR,
  input  logic [4:0]  sig_REG_ADDR,
  input  logic [15:0] sig_WDATA,
  output logic        sig_BUSY,
  output logic        sig_DONE,
  output logic [15:0] sig_RDATA,
  output logic        sig_RD_ERR,
  output logic        sig_MDCLK,
  output logic        sig_MDIO_O,
  output logic        sig_MDIO_OE,
  input  logic        sig_MDIO_I
);

  typedef enum logic [1:0] {IDLE, PRE, FRAME, TAIL} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        mdc_q, mdc_d;
  logic [5:0]  bit_q, bit_d;
  logic [31:0] sh_q, sh_d;
  logic        write_q, write_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_sh_q, err_sh_d;
  logic        rd_err_q, rd_err_d;
  logic        done_q, done_d;
  logic        tick, rise, fall;

  assign tick = (div_q == DIV_LAST);
  assign rise = (state_q != IDLE) && tick && !mdc_q;
  assign fall = (state_q != IDLE) && tick && mdc_q;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    mdc_d    = mdc_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    write_d  = write_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;
    err_sh_d = err_sh_q;
    rd_err_d = rd_err_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      mdc_d = 1'b0;
      div_d = 8'd0;
      bit_d = 6'd0;
      if (sig_REQ) begin
        write_d = sig_WRITE;
        // Read frames carry ones in TA/DATA; those bits are never driven (OE=0).
        sh_d    = {2'b01, (sig_WRITE ? 2'b01 : 2'b10), sig_PHY_ADDR, sig_REG_ADDR,
                   (sig_WRITE ? 2'b10 : 2'b11), (sig_WRITE ? sig_WDATA : 16'hFFFF)};
        state_d = PREAMBLE_EN ? PRE : FRAME;
      end
    end else begin
      if (tick) begin
        div_d = 8'd0;
        mdc_d = !mdc_q;
      end else begin
        div_d = div_q + 8'd1;
      end
      if (rise && state_q == FRAME && !write_q) begin
        if (bit_q == 6'd15) err_sh_d = sig_MDIO_I;
        else if (bit_q >= 6'd16) shadow_d = {shadow_q[14:0], sig_MDIO_I};
      end
      if (fall) begin
        bit_d = bit_q + 6'd1;
        case (state_q)
          PRE: if (bit_q == 6'd31) begin
            state_d = FRAME;
            bit_d   = 6'd0;
          end
          FRAME: begin
            sh_d = {sh_q[30:0], 1'b1};
            if (bit_q == 6'd31) begin
              state_d = TAIL;
              bit_d   = 6'd0;
            end
          end
          TAIL: begin
            state_d = IDLE;
            bit_d   = 6'd0;
            done_d  = 1'b1;
            if (!write_q) begin
              rdata_d  = shadow_q;
              rd_err_d = err_sh_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sig_CLK) begin
    if (sig_RST) begin
      state_q  <= IDLE;
      div_q    <= 8'd0;
      mdc_q    <= 1'b0;
      bit_q    <= 6'd0;
      sh_q     <= '1;
      write_q  <= 1'b0;
      shadow_q <= 16'h0000;
      rdata_q  <= 16'h0000;
      err_sh_q <= 1'b0;
      rd_err_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      mdc_q    <= mdc_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      write_q  <= write_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      err_sh_q <= err_sh_d;
      rd_err_q <= rd_err_d;
      done_q   <= done_d;
    end
  end

  // Pin values derive only from registers that move on MDC falling edges.
  assign sig_BUSY    = (state_q != IDLE);
  assign sig_DONE    = done_q;
  assign sig_RDATA   = rdata_q;
  assign sig_RD_ERR  = rd_err_q;
  assign sig_MDCLK   = mdc_q;
  assign sig_MDIO_O  = (state_q == FRAME) ? sh_q[31] : 1'b1;
  assign sig_MDIO_OE = (state_q == PRE) || ((state_q == FRAME) && (write_q || bit_q < 6'd14));

endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - scoreboard bench for mdio_master (preamble/DIV=2 and no-preamble/DIV=3 instances)
module tb_mdio_master;

  typedef struct {
    int          d;
    int          t_done;
    logic [15:0] rdata;
    logic        rd_err;
    int          nbits;
    logic [64:0] eo;
    logic [64:0] eoe;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, wr0, req1, wr1, mi0, mi1;
  logic [4:0]  phy0, rg0, phy1, rg1;
  logic [15:0] wd0, wd1;
  logic [1:0]  busy, done, rerr, mdc, mo, moe;
  logic [15:0] rd [2];

  mdio_master #(.CLK_DIV(2), .PREAMBLE_EN(1'b1)) u_dut0 (
    .sig_CLK(clk), .sig_RST(rst), .sig_REQ(req0), .sig_WRITE(wr0),
    .sig_PHY_ADDR(phy0), .sig_REG_ADDR(rg0), .sig_WDATA(wd0),
    .sig_BUSY(busy[0]), .sig_DONE(done[0]), .sig_RDATA(rd[0]), .sig_RD_ERR(rerr[0]),
    .sig_MDCLK(mdc[0]), .sig_MDIO_O(mo[0]), .sig_MDIO_OE(moe[0]), .sig_MDIO_I(mi0));

  mdio_master #(.CLK_DIV(3), .PREAMBLE_EN(1'b0)) u_dut1 (
    .sig_CLK(clk), .sig_RST(rst), .sig_REQ(req1), .sig_WRITE(wr1),
    .sig_PHY_ADDR(phy1), .sig_REG_ADDR(rg1), .sig_WDATA(wd1),
    .sig_BUSY(busy[1]), .sig_DONE(done[1]), .sig_RDATA(rd[1]), .sig_RD_ERR(rerr[1]),
    .sig_MDCLK(mdc[1]), .sig_MDIO_O(mo[1]), .sig_MDIO_OE(moe[1]), .sig_MDIO_I(mi1));

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input int d, input bit pre, input int div, input bit w,
                              input logic [4:0] p, input logic [4:0] r, input logic [15:0] wdat,
                              input logic [15:0] er, input logic ee, input int t0);
    exp_t e;
    logic [31:0] fw, fo;
    fw = {2'b01, (w ? 2'b01 : 2'b10), p, r, (w ? 2'b10 : 2'b00), (w ? wdat : 16'h0000)};
    fo = w ? 32'hFFFF_FFFF : 32'hFFFC_0000;
    e.d      = d;
    e.nbits  = pre ? 65 : 33;
    e.eo     = pre ? {32'hFFFF_FFFF, fw, 1'b1} : {32'h0, fw, 1'b1};
    e.eoe    = pre ? {32'hFFFF_FFFF, fo, 1'b0} : {32'h0, fo, 1'b0};
    e.t_done = t0 + 1 + e.nbits * 2 * div;
    e.rdata  = er;
    e.rd_err = ee;
    return e;
  endfunction

  // Monitor: capture MDIO/OE at each MDC rising edge, check everything on DONE.
  logic [64:0] cap_o [2];
  logic [64:0] cap_oe [2];
  int          ncap [2];
  logic [1:0]  mdc_p = 2'b00;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        ncap[d] = 0; cap_o[d] = '0; cap_oe[d] = '0;
      end else begin
        if (mdc[d] && !mdc_p[d]) begin
          cap_o[d]  = {cap_o[d][63:0], mo[d]};
          cap_oe[d] = {cap_oe[d][63:0], moe[d]};
          ncap[d]++;
        end
        if (done[d]) begin
          if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done dut=%0d actual=1 required=0 cyc=%0d", d, cyc);
          end else begin
            mon_e = q.pop_front();
            chk("dut_id", 65'(d), 65'(mon_e.d));
            chk("done_cycle", 65'(cyc), 65'(mon_e.t_done));
            chk("bit_count", 65'(ncap[d]), 65'(mon_e.nbits));
            chk("mdio_bits", cap_o[d] & mon_e.eoe, mon_e.eo & mon_e.eoe);
            chk("oe_bits", cap_oe[d], mon_e.eoe);
            chk("rdata", 65'(rd[d]), 65'(mon_e.rdata));
            chk("rd_err", 65'(rerr[d]), 65'(mon_e.rd_err));
            chk("busy_at_done", 65'(busy[d]), 65'(0));
            chk("mdclk_at_done", 65'(mdc[d]), 65'(0));
          end
          ncap[d] = 0; cap_o[d] = '0; cap_oe[d] = '0;
        end
      end
    end
    mdc_p = mdc;
  end

  // PHY model for dut0: drives TA2=0 and DATA after MDC falling edges when enabled.
  int          fcnt = 0;
  logic        phy_mode = 1'b0;
  logic [15:0] phy_data = 16'h0000;
  logic        busy0_p = 1'b0;
  logic        mdc0_p = 1'b0;

  always @(negedge clk) begin
    if (busy[0] && !busy0_p) fcnt = 0;
    else if (!mdc[0] && mdc0_p) fcnt++;
    busy0_p = busy[0];
    mdc0_p  = mdc[0];
    if (phy_mode && fcnt == 47) mi0 = 1'b0;
    else if (phy_mode && fcnt >= 48 && fcnt <= 63) mi0 = phy_data[4'(63 - fcnt)];
    else mi0 = 1'b1;
  end

  task automatic issue0(input bit w, input logic [4:0] p, input logic [4:0] r, input logic [15:0] wdat,
                        input logic [15:0] er, input logic ee, input bit push);
    @(negedge clk);
    wr0 = w; phy0 = p; rg0 = r; wd0 = wdat; req0 = 1'b1;
    if (push) q.push_back(mk(0, 1'b1, 2, w, p, r, wdat, er, ee, cyc));
    @(negedge clk);
    req0 = 1'b0;
    chk("t0p1_busy", 65'(busy[0]), 65'(1));
    chk("t0p1_mdclk", 65'(mdc[0]), 65'(0));
    chk("t0p1_oe", 65'(moe[0]), 65'(1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || busy != 2'b00) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL wait_idle_timeout actual=%0d pending required=0", q.size());
    end
  endtask

  initial begin
    int t0;
    int n;
    rst = 1'b1; req0 = 1'b0; wr0 = 1'b0; phy0 = '0; rg0 = '0; wd0 = '0;
    req1 = 1'b0; wr1 = 1'b0; phy1 = '0; rg1 = '0; wd1 = '0; mi1 = 1'b1;
    repeat (3) @(negedge clk);
    req0 = 1'b1;
    @(negedge clk);
    chk("rst_busy", 65'(busy[0]), 65'(0));
    chk("rst_done", 65'(done[0]), 65'(0));
    chk("rst_rdata", 65'(rd[0]), 65'(16'h0000));
    chk("rst_rd_err", 65'(rerr[0]), 65'(0));
    chk("rst_mdclk", 65'(mdc[0]), 65'(0));
    chk("rst_mdio_o", 65'(mo[0]), 65'(1));
    chk("rst_oe", 65'(moe[0]), 65'(0));
    req0 = 1'b0;
    rst = 1'b0;

    issue0(1'b1, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0, 1'b1);
    wait_idle();

    phy_mode = 1'b1; phy_data = 16'h796D;
    issue0(1'b0, 5'h03, 5'h02, 16'h0000, 16'h796D, 1'b0, 1'b1);
    wait_idle();

    phy_mode = 1'b0;
    issue0(1'b0, 5'h1F, 5'h01, 16'h0000, 16'hFFFF, 1'b1, 1'b1);
    wait_idle();

    issue0(1'b1, 5'h0C, 5'h11, 16'hA5C3, 16'hFFFF, 1'b1, 1'b1);
    repeat (100) @(negedge clk);
    wr0 = 1'b0; phy0 = 5'h1F; rg0 = 5'h1F; wd0 = 16'hFFFF; req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    wait_idle();

    @(negedge clk);
    wr0 = 1'b1; phy0 = 5'h0A; rg0 = 5'h05; wd0 = 16'h5A5A; req0 = 1'b1;
    t0 = cyc;
    q.push_back(mk(0, 1'b1, 2, 1'b1, 5'h0A, 5'h05, 16'h5A5A, 16'hFFFF, 1'b1, t0));
    q.push_back(mk(0, 1'b1, 2, 1'b1, 5'h0A, 5'h05, 16'h5A5A, 16'hFFFF, 1'b1, t0 + 261));
    repeat (300) @(negedge clk);
    req0 = 1'b0;
    wait_idle();

    phy_mode = 1'b1; phy_data = 16'h796D;
    issue0(1'b0, 5'h03, 5'h02, 16'h0000, 16'h0000, 1'b0, 1'b0);
    n = 0;
    while (fcnt != 53 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("reach_data_bit5", 65'(fcnt), 65'(53));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 65'(busy[0]), 65'(0));
    chk("abort_oe", 65'(moe[0]), 65'(0));
    chk("abort_mdclk", 65'(mdc[0]), 65'(0));
    chk("abort_done", 65'(done[0]), 65'(0));
    chk("abort_rdata", 65'(rd[0]), 65'(16'h0000));
    chk("abort_rd_err", 65'(rerr[0]), 65'(0));
    rst = 1'b0;
    repeat (20) @(negedge clk);

    phy_data = 16'hC3A5;
    issue0(1'b0, 5'h07, 5'h1D, 16'h0000, 16'hC3A5, 1'b0, 1'b1);
    wait_idle();
    phy_mode = 1'b0;

    @(negedge clk);
    wr1 = 1'b1; phy1 = 5'h12; rg1 = 5'h0A; wd1 = 16'h8001; req1 = 1'b1;
    q.push_back(mk(1, 1'b0, 3, 1'b1, 5'h12, 5'h0A, 16'h8001, 16'h0000, 1'b0, cyc));
    @(negedge clk);
    req1 = 1'b0;
    chk("np_first_bit", 65'(mo[1]), 65'(0));
    chk("np_first_oe", 65'(moe[1]), 65'(1));
    chk("np_busy", 65'(busy[1]), 65'(1));
    wait_idle();

    repeat (5) @(negedge clk);
    chk("queue_drained", 65'(q.size()), 65'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
